// File: rtl/motor_relay_sequencer.sv
// Relay sequencer for a single-phase AC motor: dead-time interlock between directions and a timed start winding.
// Optional macro MOTOR_REV_COUNT_EN adds a saturating reversal counter output rev_count.
module motor_relay_sequencer #(
   parameter int unsigned DEAD_CYCLES  = 16,
   parameter int unsigned START_CYCLES = 64,
   parameter int unsigned CNT_W        = 8
) (
   input  logic       orgclk,
   input  logic       rst_n,
   input  logic [1:0] pulse,
   input  logic       stop,
   output logic       fwd_relay,
   output logic       rev_relay,
   output logic       start_relay,
   output logic       busy,
   output logic [1:0] dir,
`ifdef MOTOR_REV_COUNT_EN
   output logic [7:0] rev_count,
`endif
   output logic       fault
);

   localparam int unsigned DIR_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DEAD  = 2'd1,
      ST_START = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIR_W-1:0]   target_q, target_d;
   logic               fault_q, fault_d;
   logic               fwd_q, fwd_d;
   logic               rev_q, rev_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic [DIR_W-1:0]   dir_q, dir_d;
   logic               req_valid;
   logic               energised_d;

   assign req_valid = (pulse == 2'b01) || (pulse == 2'b10);

   // Next state, counter, target and fault; first matching rule wins.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      target_d = target_q;
      fault_d  = fault_q;
      if (stop || (pulse == 2'b11)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         fault_d = (pulse == 2'b11);
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  target_d = pulse;
                  state_d  = ST_DEAD;
                  cnt_d    = '0;
               end
            end
            ST_DEAD: begin
               if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
                  state_d = ST_START;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  // A late request retargets without extending the dead time.
                  if (req_valid) target_d = pulse;
               end
            end
            ST_START: begin
               if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else if (req_valid && (pulse != target_q)) begin
                  target_d = pulse;
                  state_d  = ST_DEAD;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (req_valid && (pulse != target_q)) begin
                  target_d = pulse;
                  state_d  = ST_DEAD;
                  cnt_d    = '0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decoded from the next state so they move on the same edge as the state.
   always_comb begin
      energised_d = (state_d == ST_START) || (state_d == ST_RUN);
      fwd_d       = energised_d && (target_d == 2'b01);
      rev_d       = energised_d && (target_d == 2'b10);
      start_d     = (state_d == ST_START);
      busy_d      = (state_d == ST_DEAD) || (state_d == ST_START);
      dir_d       = energised_d ? target_d : 2'b00;
   end

   always_ff @(posedge orgclk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= '0;
         fault_q  <= 1'b0;
         fwd_q    <= 1'b0;
         rev_q    <= 1'b0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         dir_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         fault_q  <= fault_d;
         fwd_q    <= fwd_d;
         rev_q    <= rev_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
         dir_q    <= dir_d;
      end
   end

`ifdef MOTOR_REV_COUNT_EN
   logic [7:0] rev_cnt_q, rev_cnt_d;
   logic       reversal;

   // Accepted reversal: leaving an energised state back into dead time.
   always_comb begin
      reversal  = ((state_q == ST_START) || (state_q == ST_RUN)) && (state_d == ST_DEAD);
      rev_cnt_d = rev_cnt_q;
      if (reversal && (rev_cnt_q != 8'hFF)) rev_cnt_d = rev_cnt_q + 8'(1);
   end

   always_ff @(posedge orgclk) begin
      if (!rst_n) rev_cnt_q <= '0;
      else        rev_cnt_q <= rev_cnt_d;
   end

   assign rev_count = rev_cnt_q;
`endif

   assign fwd_relay   = fwd_q;
   assign rev_relay   = rev_q;
   assign start_relay = start_q;
   assign busy        = busy_q;
   assign dir         = dir_q;
   assign fault       = fault_q;

endmodule
